// File: rtl/pkt_fifo_pkg.sv
// Shared types and helpers for the packet-aware FIFO.
package pkt_fifo_pkg;

  localparam int PKT_BW = 8;

  function automatic int flen(input int lg);
    return 1 << lg;
  endfunction

  // Default-width storage word; the top builds the same shape sized by BW.
  typedef struct packed {
    logic              last;
    logic [PKT_BW-1:0] data;
  } pkt_word_t;

  typedef enum logic {
    ST_PASS    = 1'b0,
    ST_DISCARD = 1'b1
  } dsc_state_t;

  // Distance a-b for pointers carrying one wrap bit above the index.
  function automatic int ptr_diff(input int a, input int b, input int lg);
    return (a - b) & ((1 << (lg + 1)) - 1);
  endfunction

endpackage

// File: rtl/pkt_fifo_mem.sv
// Simple dual-port RAM: synchronous write, asynchronous read.
module pkt_fifo_mem #(
  parameter int W  = 9,
  parameter int AW = 4
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);

  logic [W-1:0] mem [2**AW];

  always_ff @(posedge i_clk)
    if (i_we) mem[i_waddr] <= i_wdata;

  assign o_rdata = mem[i_raddr];

endmodule

// File: rtl/pkt_fifo.sv
// Packet FIFO: words are visible to the reader only once their packet's last word lands.
module pkt_fifo
  import pkt_fifo_pkg::*;
#(
  parameter int BW               = 8,
  parameter int LGFLEN           = 4,
  parameter int AFULL_TH         = 12,
  parameter bit OPT_DROP_ON_FULL = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_wr,
  input  logic [BW-1:0]     i_data,
  input  logic              i_last,
  input  logic              i_drop,
  output logic              o_full,
  output logic              o_afull,
  output logic [LGFLEN:0]   o_fill,
  input  logic              i_rd,
  output logic [BW-1:0]     o_data,
  output logic              o_last,
  output logic              o_empty,
  output logic [LGFLEN:0]   o_pkts,
  output logic              o_overflow,
  input  logic              i_clr_ovf
);

  localparam int FLEN = flen(LGFLEN);
  localparam int PW   = LGFLEN + 1;

  typedef struct packed {
    logic          last;
    logic [BW-1:0] data;
  } word_t;

  logic [PW-1:0] wr_ptr, cm_ptr, rd_ptr;
  logic [PW-1:0] wr_nxt, cm_nxt, rd_nxt;
  dsc_state_t    state, state_nxt;
  logic          w_wr, w_rd, ovf_drop, commit, pop;
  word_t         wdata, rdata;

  assign o_full   = (ptr_diff(32'(wr_ptr), 32'(rd_ptr), LGFLEN) == FLEN);
  assign o_afull  = (32'(o_fill) >= AFULL_TH);

  assign w_wr     = i_wr & ~o_full & ~i_drop & (state == ST_PASS);
  assign w_rd     = i_rd & ~o_empty;
  assign ovf_drop = OPT_DROP_ON_FULL & i_wr & o_full & ~i_drop & (state == ST_PASS);
  assign commit   = w_wr & i_last;
  assign pop      = w_rd & o_last;

  assign wdata    = '{last: i_last, data: i_data};
  assign o_data   = rdata.data;
  assign o_last   = rdata.last;

  pkt_fifo_mem #(.W($bits(word_t)), .AW(LGFLEN)) u_mem (
    .i_clk  (i_clk),
    .i_we   (w_wr),
    .i_waddr(wr_ptr[LGFLEN-1:0]),
    .i_wdata(wdata),
    .i_raddr(rd_ptr[LGFLEN-1:0]),
    .o_rdata(rdata)
  );

  always_comb begin
    wr_nxt    = wr_ptr;
    cm_nxt    = cm_ptr;
    rd_nxt    = rd_ptr;
    state_nxt = state;
    // Abort and overflow both rewind the writer to the last commit point.
    if (i_drop || ovf_drop) wr_nxt = cm_ptr;
    else if (w_wr)          wr_nxt = wr_ptr + PW'(1);
    if (commit) cm_nxt = wr_ptr + PW'(1);
    if (w_rd)   rd_nxt = rd_ptr + PW'(1);
    case (state)
      ST_PASS:    if (ovf_drop) state_nxt = ST_DISCARD;
      ST_DISCARD: if (i_drop || (i_wr && i_last)) state_nxt = ST_PASS;
      default:    state_nxt = ST_PASS;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr     <= '0;
      cm_ptr     <= '0;
      rd_ptr     <= '0;
      o_fill     <= '0;
      o_pkts     <= '0;
      o_empty    <= 1'b1;
      o_overflow <= 1'b0;
      state      <= ST_PASS;
    end else begin
      wr_ptr  <= wr_nxt;
      cm_ptr  <= cm_nxt;
      rd_ptr  <= rd_nxt;
      state   <= state_nxt;
      o_fill  <= PW'(ptr_diff(32'(wr_nxt), 32'(rd_nxt), LGFLEN));
      o_empty <= (rd_nxt == cm_nxt);
      case ({commit, pop})
        2'b10:   o_pkts <= o_pkts + PW'(1);
        2'b01:   o_pkts <= o_pkts - PW'(1);
        default: o_pkts <= o_pkts;
      endcase
      if (ovf_drop)       o_overflow <= 1'b1;
      else if (i_clr_ovf) o_overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pkt_fifo.sv
// Randomized plus directed bench for pkt_fifo, both overflow policies side by side.
module tb_pkt_fifo;
  localparam int BW   = 8;
  localparam int LG   = 4;
  localparam int FLEN = 16;
  localparam int TH   = 12;

  logic clk = 1'b0;
  logic rst, wr, last, drop, rd, clr;
  logic [BW-1:0] din;

  logic          full_o [2], afull_o [2], empty_o [2], last_o [2], ovf_o [2];
  logic [LG:0]   fill_o [2], pkts_o [2];
  logic [BW-1:0] data_o [2];

  int checks = 0;
  int errors = 0;

  // Reference: committed and pending word queues, entries are {last,data}.
  logic [BW:0] cq [2][$];
  logic [BW:0] uq [2][$];
  bit          dsc [2];
  bit          ovf [2];

  always #5 clk = ~clk;

  pkt_fifo #(.BW(BW), .LGFLEN(LG), .AFULL_TH(TH), .OPT_DROP_ON_FULL(1'b1)) u_drop (
    .i_clk(clk), .i_reset(rst), .i_wr(wr), .i_data(din), .i_last(last), .i_drop(drop),
    .o_full(full_o[0]), .o_afull(afull_o[0]), .o_fill(fill_o[0]), .i_rd(rd),
    .o_data(data_o[0]), .o_last(last_o[0]), .o_empty(empty_o[0]), .o_pkts(pkts_o[0]),
    .o_overflow(ovf_o[0]), .i_clr_ovf(clr)
  );

  pkt_fifo #(.BW(BW), .LGFLEN(LG), .AFULL_TH(TH), .OPT_DROP_ON_FULL(1'b0)) u_hold (
    .i_clk(clk), .i_reset(rst), .i_wr(wr), .i_data(din), .i_last(last), .i_drop(drop),
    .o_full(full_o[1]), .o_afull(afull_o[1]), .o_fill(fill_o[1]), .i_rd(rd),
    .o_data(data_o[1]), .o_last(last_o[1]), .o_empty(empty_o[1]), .o_pkts(pkts_o[1]),
    .o_overflow(ovf_o[1]), .i_clr_ovf(clr)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic int npk(input int d);
    int n = 0;
    for (int i = 0; i < cq[d].size(); i++) if (cq[d][i][BW]) n++;
    return n;
  endfunction

  task automatic model_clear();
    for (int d = 0; d < 2; d++) begin
      cq[d].delete(); uq[d].delete(); dsc[d] = 0; ovf[d] = 0;
    end
  endtask

  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      bit f, set;
      f   = (cq[d].size() + uq[d].size() == FLEN);
      set = 0;
      if (rd && cq[d].size() > 0) void'(cq[d].pop_front());
      if (drop) begin
        uq[d].delete(); dsc[d] = 0;
      end else if (dsc[d]) begin
        if (wr && last) dsc[d] = 0;
      end else if (wr) begin
        if (!f) begin
          uq[d].push_back({last, din});
          if (last) begin
            for (int i = 0; i < uq[d].size(); i++) cq[d].push_back(uq[d][i]);
            uq[d].delete();
          end
        end else if (d == 0) begin
          uq[d].delete(); dsc[d] = 1; set = 1;
        end
      end
      if (set) ovf[d] = 1;
      else if (clr) ovf[d] = 0;
    end
  endtask

  task automatic check_all(input string tag);
    for (int d = 0; d < 2; d++) begin
      int n;
      n = cq[d].size() + uq[d].size();
      chk($sformatf("%s.fill%0d", tag, d),  32'(fill_o[d]),  32'(n));
      chk($sformatf("%s.pkts%0d", tag, d),  32'(pkts_o[d]),  32'(npk(d)));
      chk($sformatf("%s.empty%0d", tag, d), 32'(empty_o[d]), 32'(cq[d].size() == 0));
      chk($sformatf("%s.full%0d", tag, d),  32'(full_o[d]),  32'(n == FLEN));
      chk($sformatf("%s.afull%0d", tag, d), 32'(afull_o[d]), 32'(n >= TH));
      chk($sformatf("%s.ovf%0d", tag, d),   32'(ovf_o[d]),   32'(ovf[d]));
      if (cq[d].size() > 0)
        chk($sformatf("%s.head%0d", tag, d), 32'({last_o[d], data_o[d]}), 32'(cq[d][0]));
    end
  endtask

  task automatic cyc(input string tag, input bit w, input logic [BW-1:0] dd, input bit l,
                     input bit dr, input bit r, input bit c);
    wr = w; din = dd; last = l; drop = dr; rd = r; clr = c;
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    wr = 0; last = 0; drop = 0; rd = 0; clr = 0;
    #1;
    model_clear();
    check_all(tag);
    chk({tag, ".fill_rst"}, 32'(fill_o[0]), 32'd0);
    chk({tag, ".empty_rst"}, 32'(empty_o[0]), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_all(tag);
  endtask

  initial begin
    rst = 1'b1; wr = 0; din = '0; last = 0; drop = 0; rd = 0; clr = 0;
    model_clear();
    do_reset("init");

    // Three-word packet, visible only after its last word.
    cyc("t1", 1, 8'hA0, 0, 0, 0, 0);
    cyc("t1", 1, 8'hB1, 0, 0, 0, 0);
    chk("t1.empty_pre", 32'(empty_o[0]), 32'd1);
    cyc("t1", 1, 8'hC2, 1, 0, 0, 0);
    chk("t1.pkts", 32'(pkts_o[0]), 32'd1);
    chk("t1.fill", 32'(fill_o[0]), 32'd3);
    for (int i = 0; i < 3; i++) cyc("t1rd", 0, 8'h00, 0, 0, 1, 0);
    chk("t1.pkts_end", 32'(pkts_o[0]), 32'd0);

    // Abort a partial packet, then a single-word packet.
    cyc("t2", 1, 8'hD3, 0, 0, 0, 0);
    cyc("t2", 1, 8'hE4, 0, 0, 0, 0);
    chk("t2.fill_peak", 32'(fill_o[0]), 32'd2);
    cyc("t2", 1, 8'h99, 1, 1, 0, 0);
    chk("t2.fill_drop", 32'(fill_o[0]), 32'd0);
    cyc("t2", 1, 8'hF5, 1, 0, 0, 0);
    chk("t2.head", 32'(data_o[0]), 32'h0F5);
    cyc("t2rd", 0, 8'h00, 0, 0, 1, 0);

    // Overflow with 10 committed words and an 8-word packet.
    do_reset("t3rst");
    for (int i = 0; i < 10; i++) cyc("t3a", 1, 8'(8'h10 + i), i == 9, 0, 0, 0);
    for (int i = 0; i < 8; i++)  cyc("t3b", 1, 8'(8'h40 + i), i == 7, 0, 0, 0);
    chk("t3.ovf", 32'(ovf_o[0]), 32'd1);
    chk("t3.fill", 32'(fill_o[0]), 32'd10);
    chk("t3.pkts", 32'(pkts_o[0]), 32'd1);
    chk("t3.hold_fill", 32'(fill_o[1]), 32'd16);
    chk("t3.hold_ovf", 32'(ovf_o[1]), 32'd0);
    cyc("t4drop", 0, 8'h00, 0, 1, 0, 0);
    chk("t4.hold_fill", 32'(fill_o[1]), 32'd10);
    cyc("t3clr", 0, 8'h00, 0, 0, 0, 1);
    chk("t3.ovf_clr", 32'(ovf_o[0]), 32'd0);
    for (int i = 0; i < 11; i++) cyc("t3rd", 0, 8'h00, 0, 0, 1, 0);

    // Back-to-back single-word packets across pointer wrap.
    do_reset("t5rst");
    for (int i = 0; i < 40; i++) begin
      cyc("t5", 1, 8'($urandom), 1, 0, 1, 0);
      chk("t5.pkts", 32'(pkts_o[0]), 32'd1);
      chk("t5.afull", 32'(afull_o[0]), 32'd0);
    end

    // Reset in the middle of a packet.
    do_reset("t6rst");
    for (int i = 0; i < 5; i++) cyc("t6a", 1, 8'(8'h60 + i), i == 4, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc("t6b", 1, 8'(8'h70 + i), 0, 0, 0, 0);
    do_reset("t6mid");
    chk("t6.pkts_rst", 32'(pkts_o[0]), 32'd0);
    for (int i = 0; i < 3; i++) cyc("t6c", 1, 8'(8'h80 + i), i == 2, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc("t6rd", 0, 8'h00, 0, 0, 1, 0);

    // Randomized phases with varying read pressure.
    for (int i = 0; i < 1500; i++) begin
      int rp;
      case (i / 300)
        0: rp = 50; 1: rp = 15; 2: rp = 90; 3: rp = 60; default: rp = 35;
      endcase
      if (i == 750) do_reset("rnd_rst");
      cyc("rnd", $urandom_range(99) < 80, 8'($urandom), $urandom_range(99) < 25,
          $urandom_range(99) < 3, $urandom_range(99) < rp, $urandom_range(99) < 5);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
